// File: rtl/dcs_pkg.sv
// Shared definitions for the dual counter sequencer: state encoding and
// default widths for the counter/limit and pass-count fields.
package dcs_pkg;

    localparam int DCS_WIDTH = 8;
    localparam int DCS_REP_W = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        RUN0 = 3'd2,
        RUN1 = 3'd3,
        DONE = 3'd4
    } dcs_state_t;

endpackage

// File: rtl/dual_counter_sequencer.sv
// Sequences the dual 8-bit counter datapath: per pass it clears both
// channels, runs channel 0 to its limit, then channel 1 to its limit, and
// repeats for the programmed number of passes before pulsing done.
//
//   state | meaning
//   IDLE  | waiting for start; err and pass_cnt hold
//   CLR   | one-cycle clear of both channels
//   RUN0  | channel 0 counts until q0 reaches lim0
//   RUN1  | channel 1 counts until q1 reaches lim1, then pass ends
//   DONE  | one-cycle completion pulse
module dual_counter_sequencer
    import dcs_pkg::*;
#(
    parameter int WIDTH = DCS_WIDTH,
    parameter int REP_W = DCS_REP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] limit0,
    input  logic [WIDTH-1:0] limit1,
    input  logic [REP_W-1:0] rep,
    input  logic [WIDTH-1:0] q0,
    input  logic [WIDTH-1:0] q1,
    output logic             en0,
    output logic             en1,
    output logic             clr,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [REP_W-1:0] pass_cnt
);

    dcs_state_t       r_state;
    dcs_state_t       w_next;
    logic [WIDTH-1:0] r_lim0;
    logic [WIDTH-1:0] r_lim1;
    logic [REP_W-1:0] r_rep;
    logic             r_err;
    logic [REP_W-1:0] r_pass_cnt;

    logic             w_accept;
    logic             w_hit0;
    logic             w_hit1;
    logic             w_over0;
    logic             w_over1;
    logic             w_last_pass;

    // Start is only honoured from IDLE and never alongside abort.
    assign w_accept    = (r_state == IDLE) && start && !abort;
    assign w_hit0      = (q0 == r_lim0);
    assign w_hit1      = (q1 == r_lim1);
    assign w_over0     = (q0 > r_lim0);
    assign w_over1     = (q1 > r_lim1);
    // Looks at the count as it will be after this pass completes.
    assign w_last_pass = ((r_pass_cnt + REP_W'(1)) == r_rep);

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: abort beats overshoot beats normal progress.
    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        // rep is taken straight from the input; it is latched on this same edge.
                        w_next = (rep == '0) ? DONE : CLR;
                    end
                end
                CLR:  w_next = RUN0;
                RUN0: begin
                    if (w_over0) begin
                        w_next = IDLE;
                    end else if (w_hit0) begin
                        w_next = RUN1;
                    end
                end
                RUN1: begin
                    if (w_over1) begin
                        w_next = IDLE;
                    end else if (w_hit1) begin
                        w_next = w_last_pass ? DONE : CLR;
                    end
                end
                DONE:    w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    // Latched command fields, sticky error flag and pass counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lim0     <= '0;
            r_lim1     <= '0;
            r_rep      <= '0;
            r_err      <= 1'b0;
            r_pass_cnt <= '0;
        end else if (w_accept) begin
            r_lim0     <= limit0;
            r_lim1     <= limit1;
            r_rep      <= rep;
            r_err      <= 1'b0;
            r_pass_cnt <= '0;
        end else if (!abort) begin
            if ((r_state == RUN0) && w_over0) begin
                r_err <= 1'b1;
            end
            if (r_state == RUN1) begin
                if (w_over1) begin
                    r_err <= 1'b1;
                end else if (w_hit1) begin
                    r_pass_cnt <= r_pass_cnt + REP_W'(1);
                end
            end
        end
    end

    // Outputs decoded from state; datapath strobes drop immediately on abort.
    always_comb begin
        en0  = 1'b0;
        en1  = 1'b0;
        clr  = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            CLR: begin
                busy = 1'b1;
                clr  = !abort;
            end
            RUN0: begin
                busy = 1'b1;
                en0  = !abort && !w_hit0;
            end
            RUN1: begin
                busy = 1'b1;
                en1  = !abort && !w_hit1;
            end
            DONE:    done = !abort;
            default: ;
        endcase
    end

    assign err      = r_err;
    assign pass_cnt = r_pass_cnt;

endmodule
